// File: rtl/move_executor.sv
// move_executor: decodes a sequencer move code and drives one stepper face through a quarter turn.
// Optional HOLD_TORQUE_EN: the last turned face stays enabled until the next valid move or reset.
module move_executor #(
    parameter int STEPS_PER_QTR = 50,
    parameter int HALF_PERIOD   = 50000,
    parameter int SETUP_CYCLES  = 100,
    parameter int SETTLE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_move,
    input  logic [3:0] next_move,
    output logic       move_done,
    output logic       busy,
    output logic       bad_move,
    output logic       overrun,
    output logic [5:0] motor_step,
    output logic [5:0] motor_dir,
    output logic [5:0] motor_en,
    output logic [7:0] moves_executed
);
    localparam int SW = $clog2(SETUP_CYCLES + 1);
    localparam int HW = $clog2(HALF_PERIOD + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = (SW > HW) ? ((SW > TW) ? SW : TW) : ((HW > TW) ? HW : TW);
    localparam int NW = $clog2(STEPS_PER_QTR + 1);
    // DONE is exited on the edge that raises move_done, so the settle state itself lasts one cycle less
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;

    typedef enum logic [2:0] {IDLE, DECODE, SETUP, STEP_HI, STEP_LO, SETTLE, DONE} state_t;

    state_t          state;
    logic   [3:0]    code;
    logic   [CW-1:0] cnt;
    logic   [NW-1:0] steps;
    logic   [5:0]    onehot;
    logic            valid, reserved, cw;

    assign valid    = code inside {[4'd1:4'd12]};
    assign reserved = code > 4'd12;
    assign cw       = code inside {[4'd1:4'd6]};
    assign busy     = state != IDLE;

    // face select: codes 1..6 and 7..12 both map onto faces 0..5
    always_comb begin
        for (int i = 0; i < 6; i++) onehot[i] = (code == 4'(i + 1)) || (code == 4'(i + 7));
    end

    // move sequencer: decode, enable/dir setup, step pulse train, settle, completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            code           <= '0;
            cnt            <= '0;
            steps          <= '0;
            move_done      <= 1'b0;
            bad_move       <= 1'b0;
            overrun        <= 1'b0;
            motor_step     <= '0;
            motor_dir      <= '0;
            motor_en       <= '0;
            moves_executed <= '0;
        end else begin
            move_done <= 1'b0;
            bad_move  <= 1'b0;
            if (start_move && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_move) begin
                        code  <= next_move;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (valid) begin
                        motor_en  <= onehot;
                        motor_dir <= cw ? onehot : 6'b0;
                        cnt       <= CW'(SETUP_CYCLES);
                        steps     <= '0;
                        state     <= SETUP;
                    end else begin
                        state <= DONE;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        motor_step <= onehot;
                        cnt        <= CW'(HALF_PERIOD - 1);
                        state      <= STEP_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STEP_HI: begin
                    if (cnt == '0) begin
                        motor_step <= '0;
                        cnt        <= CW'(HALF_PERIOD - 1);
                        state      <= STEP_LO;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STEP_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (steps == NW'(STEPS_PER_QTR - 1)) begin
                        cnt   <= CW'(SETTLE_LOAD);
                        state <= (SETTLE_CYCLES > 1) ? SETTLE : DONE;
                    end else begin
                        steps      <= steps + 1'b1;
                        motor_step <= onehot;
                        cnt        <= CW'(HALF_PERIOD - 1);
                        state      <= STEP_HI;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) state <= DONE;
                    else cnt <= cnt - 1'b1;
                end
                DONE: begin
                    move_done <= 1'b1;
                    bad_move  <= reserved;
                    if (valid) moves_executed <= moves_executed + 8'd1;
                    motor_dir <= '0;
`ifndef HOLD_TORQUE_EN
                    motor_en  <= '0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_executor.sv
// tb_move_executor: randomized check of move_executor against a cycle-offset timing model.
module tb_move_executor;
    localparam int N  = 4;
    localparam int H  = 3;
    localparam int S  = 2;
    localparam int T  = 5;
    localparam int LV = 2 + S + 2 * H * N + T;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_move = 1'b0;
    logic [3:0] next_move = '0;
    logic       move_done, busy, bad_move, overrun;
    logic [5:0] motor_step, motor_dir, motor_en;
    logic [7:0] moves_executed;

    int n_vec = 0;
    int n_err = 0;

    bit         m_act = 0;
    int         m_k = 0;
    logic [3:0] m_code = '0;
    logic [7:0] m_moves = '0;
    logic       m_ovr = 1'b0;
    logic [5:0] m_held = '0;

    move_executor #(
        .STEPS_PER_QTR(N),
        .HALF_PERIOD(H),
        .SETUP_CYCLES(S),
        .SETTLE_CYCLES(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start_move(start_move),
        .next_move(next_move),
        .move_done(move_done),
        .busy(busy),
        .bad_move(bad_move),
        .overrun(overrun),
        .motor_step(motor_step),
        .motor_dir(motor_dir),
        .motor_en(motor_en),
        .moves_executed(moves_executed)
    );

    always #5 clock = ~clock;

    function automatic bit is_valid(input logic [3:0] c);
        return c >= 4'd1 && c <= 4'd12;
    endfunction

    function automatic logic [5:0] face_bit(input logic [3:0] c);
        logic [5:0] r;
        r = '0;
        if (c >= 4'd1 && c <= 4'd6) r[c - 4'd1] = 1'b1;
        else if (c >= 4'd7 && c <= 4'd12) r[c - 4'd7] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic s, input logic [3:0] m, input logic r);
        int l;
        if (r) begin
            m_act = 0; m_k = 0; m_moves = '0; m_ovr = 1'b0; m_held = '0;
        end else begin
            l = is_valid(m_code) ? LV : 2;
            if (s && !(m_act && m_k < l)) begin
                m_act = 1; m_k = 0; m_code = m;
            end else begin
                if (s) m_ovr = 1'b1;
                if (m_act) begin
                    if (m_k == l) m_act = 0;
                    else begin
                        m_k++;
                        if (m_k == l && is_valid(m_code)) begin
                            m_moves++;
`ifdef HOLD_TORQUE_EN
                            m_held = face_bit(m_code);
`endif
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare();
        int l, p;
        bit v, mid, st;
        logic [5:0] o;
        o   = face_bit(m_code);
        v   = m_act && is_valid(m_code);
        l   = is_valid(m_code) ? LV : 2;
        mid = v && m_k >= 1 && m_k < l;
        p   = m_k - 2 - S;
        st  = v && p >= 0 && p < 2 * H * N && (p % (2 * H)) < H;
        check("busy", 32'(busy), 32'(m_act && m_k < l));
        check("move_done", 32'(move_done), 32'(m_act && m_k == l));
        check("bad_move", 32'(bad_move), 32'(m_act && m_k == l && m_code > 4'd12));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("motor_en", 32'(motor_en), 32'(mid ? o : m_held));
        check("motor_dir", 32'(motor_dir), 32'((mid && m_code <= 4'd6) ? o : 6'b0));
        check("motor_step", 32'(motor_step), 32'(st ? o : 6'b0));
        check("moves_executed", 32'(moves_executed), 32'(m_moves));
    endtask

    task automatic tick(input logic s, input logic [3:0] m, input logic r);
        start_move = s;
        next_move  = m;
        reset      = r;
        @(posedge clock);
        model_step(s, m, r);
        @(negedge clock);
        compare();
    endtask

    task automatic do_move(input logic [3:0] c);
        tick(1'b1, c, 1'b0);
        for (int i = 0; i < 100 && m_act; i++) tick(1'b0, 4'($urandom), 1'b0);
    endtask

    initial begin
        tick(1'b0, 4'd0, 1'b1);
        tick(1'b0, 4'd0, 1'b1);
        tick(1'b0, 4'd0, 1'b0);
        do_move(4'd1);
        do_move(4'd12);
        do_move(4'd14);
        do_move(4'd0);
        do_move(4'd2);
        tick(1'b1, 4'd3, 1'b0);
        repeat (9) tick(1'b0, 4'd0, 1'b0);
        tick(1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 100 && m_act; i++) tick(1'b0, 4'd0, 1'b0);
        tick(1'b1, 4'd2, 1'b0);
        repeat (7) tick(1'b0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 1'b1);
        do_move(4'd2);
        for (int n = 0; n < 120; n++) begin
            tick(1'b1, 4'($urandom), 1'b0);
            for (int i = 0; i < 100 && m_act; i++) begin
                int r;
                r = $urandom_range(0, 199);
                tick(r < 4, 4'($urandom), r == 199);
            end
            repeat ($urandom_range(0, 2)) tick(1'b0, 4'($urandom), 1'b0);
        end
        tick(1'b0, 4'd0, 1'b1);
        for (int n = 0; n < 256; n++) do_move(4'($urandom_range(1, 12)));
        check("wrap", 32'(moves_executed), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/move_executor.md
Name: move_executor

Overview:
- Responder side of the sequencer move handshake: accepts one 4-bit move code per single-cycle start_move pulse.
- Decodes the code into a cube face and a turn direction, then drives that face's stepper driver with step/dir/enable for one quarter turn.
- Returns a single-cycle move_done pulse when the turn has completed and the motor has settled.
- Sits between the sequencer and the six stepper-driver pin groups.

Parameters:
- STEPS_PER_QTR, 50, step pulses per quarter turn (200-step motor).
- HALF_PERIOD, 50000, clock cycles per step-high phase and per step-low phase (1 kHz at 100 MHz); must be >= 1.
- SETUP_CYCLES, 100, cycles of enable/dir setup before the first step rises; must be >= 1.
- SETTLE_CYCLES, 1000000, cycles after the last step falls before move_done; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start_move  in  1  one-cycle request pulse; next_move is valid in the same cycle
- next_move  in  4  move code
- move_done  out  1  one-cycle completion pulse
- busy  out  1  high whenever state != IDLE
- bad_move  out  1  one-cycle pulse, coincident with move_done, for reserved codes
- overrun  out  1  sticky; set when start_move arrives while busy
- motor_step  out  6  step pulse per face, index 0..5 = U,D,F,B,L,R
- motor_dir  out  6  1 = clockwise, per face
- motor_en  out  6  driver enable per face, active-high
- moves_executed  out  8  count of completed valid turns; wraps 255 -> 0

Behaviour:
- Reset: all outputs are 0 and state = IDLE. Reset mid-move aborts the move on the next edge: step, en and dir drop, and no move_done is issued.
- Code map:
  - 0: null move.
  - 1..6: clockwise turn of face code-1.
  - 7..12: counter-clockwise turn of face code-7.
  - 13..15: reserved.
- IDLE: start_move=1 latches next_move and goes to DECODE. Otherwise hold.
- DECODE (1 cycle):
  - Code 0 -> DONE (move_done only).
  - Reserved code -> DONE with bad_move.
  - Valid code -> set motor_en[face]=1 and motor_dir[face]=CW; load the setup counter; go to SETUP.
- SETUP: hold for SETUP_CYCLES, then go to STEP_HI.
- STEP_HI: motor_step[face]=1 for HALF_PERIOD cycles, then go to STEP_LO.
- STEP_LO: motor_step[face]=0 for HALF_PERIOD cycles, then increment the step count.
  - If step count == STEPS_PER_QTR, go to SETTLE.
  - Otherwise go to STEP_HI.
- SETTLE: hold for SETTLE_CYCLES, then go to DONE.
- DONE (1 cycle):
  - move_done=1.
  - For valid turns, moves_executed increments.
  - motor_en and motor_dir clear.
  - Next state is IDLE.
- Only the active face's bits are ever nonzero; all other bits of step/dir/en stay 0.
- Latency, measured from the edge that samples start_move:
  - Valid move: move_done is high exactly 2+SETUP_CYCLES+2*HALF_PERIOD*STEPS_PER_QTR+SETTLE_CYCLES cycles later. The first step rises 2+SETUP_CYCLES cycles later.
  - Code 0 or reserved code: move_done is high exactly 2 cycles later.
  - The 2-cycle minimum guarantees the sequencer is in its wait-for-done state before move_done appears.
- Counters are sized to $clog2(param+1). Comparisons are unsigned. There is no overflow except the moves_executed wrap.
- start_move in any state other than IDLE, including DONE, is dropped and sets overrun. Only reset clears overrun.
- move_done is never held for more than one cycle and never repeats without a new accepted start_move.

Optional Feature:
- Macro HOLD_TORQUE_EN.
- When defined:
  - In DONE, motor_en of the just-turned face stays at 1 while motor_dir clears.
  - The face stays enabled until the next valid move's DECODE, which clears all enables before setting the new face, or until reset.
  - Null and reserved codes leave the held enable unchanged.
- When undefined: all enables clear in DONE as described above.

Test Plan:
- Bench params STEPS_PER_QTR=4, HALF_PERIOD=3, SETUP_CYCLES=2, SETTLE_CYCLES=5, and all tests below use them.
- Code 1 -> motor_en=6'b000001 and motor_dir=6'b000001; first step rise at +4; exactly 4 pulses on motor_step[0], each 3 high / 3 low; move_done at +33; moves_executed=1; busy low the cycle after done.
- Code 12 -> motor_en=6'b100000 and motor_dir=0; 4 pulses on motor_step[5]; move_done at +33; no activity on other bits.
- Code 14 -> move_done and bad_move both pulse at +2; motor pins stay 0; moves_executed unchanged. Code 0 -> move_done at +2 with bad_move=0.
- Code 3, then a second start_move at +10 -> overrun=1 and stays 1; the first move completes normally; exactly one move_done.
- Code 2, then reset at +8 -> all outputs 0 on the next edge; no move_done; a following code 2 completes in 33 cycles.
- 256 null-free valid moves -> moves_executed wraps to 0. With HOLD_TORQUE_EN: after code 1, motor_en[0] stays 1 until code 2's DECODE sets motor_en=6'b000010.
